// File: rtl/seg7_pkg.sv
// Shared types and active-low segment patterns for the HEX digit decoder.
// Bit order is g..a, so bit 0 drives segment a.
package seg7_pkg;

  typedef logic [6:0] seg_t;

  localparam seg_t SEG_0   = 7'b1000000;
  localparam seg_t SEG_1   = 7'b1111001;
  localparam seg_t SEG_2   = 7'b0100100;
  localparam seg_t SEG_3   = 7'b0110000;
  localparam seg_t SEG_4   = 7'b0011001;
  localparam seg_t SEG_5   = 7'b0010010;
  localparam seg_t SEG_6   = 7'b0000010;
  localparam seg_t SEG_7   = 7'b1111000;
  localparam seg_t SEG_8   = 7'b0000000;
  localparam seg_t SEG_9   = 7'b0010000;
  localparam seg_t SEG_A   = 7'b0001000;
  localparam seg_t SEG_B   = 7'b0000011;
  localparam seg_t SEG_C   = 7'b1000110;
  localparam seg_t SEG_D   = 7'b0100001;
  localparam seg_t SEG_E   = 7'b0000110;
  localparam seg_t SEG_F   = 7'b0001110;
  localparam seg_t SEG_OFF = 7'b1111111;

  // Patterns are stored active-low; invert them for boards that light on a 1.
  function automatic seg_t seg_polarity(input seg_t seg, input bit active_low);
    return active_low ? seg : ~seg;
  endfunction

endpackage

// File: rtl/seg7_lut.sv
// Combinational nibble-to-segment lookup producing the active-low pattern.
module seg7_lut
  import seg7_pkg::*;
#(
  parameter bit HEX_MODE = 1'b1
) (
  input  logic [3:0] bcd,
  output seg_t       seg
);

  // Letter codes collapse to blank when the digit is decimal-only.
  always_comb begin
    seg = SEG_OFF;
    case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      4'd10:   seg = HEX_MODE ? SEG_A : SEG_OFF;
      4'd11:   seg = HEX_MODE ? SEG_B : SEG_OFF;
      4'd12:   seg = HEX_MODE ? SEG_C : SEG_OFF;
      4'd13:   seg = HEX_MODE ? SEG_D : SEG_OFF;
      4'd14:   seg = HEX_MODE ? SEG_E : SEG_OFF;
      4'd15:   seg = HEX_MODE ? SEG_F : SEG_OFF;
      default: seg = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/seg7_decoder.sv
// Registered 7-segment decoder for one HEX digit, with blanking and
// selectable output polarity; one cycle from bcd/blank to leds.
module seg7_decoder
  import seg7_pkg::*;
#(
  parameter bit ACTIVE_LOW = 1'b1,
  parameter bit HEX_MODE   = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] bcd,
  input  logic       blank,
  output logic [6:0] leds
);

  seg_t lut_s;
  seg_t next_s;
  seg_t leds_r;

  seg7_lut #(
    .HEX_MODE(HEX_MODE)
  ) u_lut (
    .bcd(bcd),
    .seg(lut_s)
  );

  // Blanking is applied in active-low form before the polarity flip.
  always_comb begin
    next_s = seg_polarity(SEG_OFF, ACTIVE_LOW);
    if (blank) begin
      next_s = seg_polarity(SEG_OFF, ACTIVE_LOW);
    end else begin
      next_s = seg_polarity(lut_s, ACTIVE_LOW);
    end
  end

  // Output register; reset takes priority and shows a dark digit.
  always_ff @(posedge clk) begin
    if (reset) begin
      leds_r <= seg_polarity(SEG_OFF, ACTIVE_LOW);
    end else begin
      leds_r <= next_s;
    end
  end

  assign leds = leds_r;

endmodule

// File: tb/tb_seg7_decoder.sv
// Self-checking bench: three decoder variants share stimulus and are compared
// against a table-driven reference of the display rules.
module tb_seg7_decoder;

  logic       clk = 1'b0;
  logic       reset;
  logic       blank;
  logic [3:0] bcd;
  logic [6:0] leds_def;
  logic [6:0] leds_dec;
  logic [6:0] leds_pos;

  int tests = 0;
  int fails = 0;

  logic [6:0] lit_low [16];
  logic [6:0] prev_def, prev_dec, prev_pos;
  bit         have_prev = 1'b0;

  always #5 clk = ~clk;

  seg7_decoder u_def (
    .clk(clk), .reset(reset), .bcd(bcd), .blank(blank), .leds(leds_def)
  );

  seg7_decoder #(.ACTIVE_LOW(1'b1), .HEX_MODE(1'b0)) u_dec (
    .clk(clk), .reset(reset), .bcd(bcd), .blank(blank), .leds(leds_dec)
  );

  seg7_decoder #(.ACTIVE_LOW(1'b0), .HEX_MODE(1'b1)) u_pos (
    .clk(clk), .reset(reset), .bcd(bcd), .blank(blank), .leds(leds_pos)
  );

  function automatic logic [6:0] model(input bit r, input bit b, input int code,
                                       input bit hexm, input bit al);
    logic [6:0] p;
    if (r || b || (!hexm && code > 9)) p = 7'b1111111;
    else                               p = lit_low[code];
    return al ? p : ~p;
  endfunction

  task automatic check(input string tag, input logic [6:0] obs, input logic [6:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: leds=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic step(input bit r, input bit b, input int d, input string tag);
    logic [6:0] e_def, e_dec, e_pos;
    reset = r;
    blank = b;
    bcd   = 4'(d);
    #1;
    if (have_prev) begin
      check({tag, "_hold_def"}, leds_def, prev_def);
      check({tag, "_hold_dec"}, leds_dec, prev_dec);
      check({tag, "_hold_pos"}, leds_pos, prev_pos);
    end
    @(posedge clk);
    #1;
    e_def = model(r, b, d, 1'b1, 1'b1);
    e_dec = model(r, b, d, 1'b0, 1'b1);
    e_pos = model(r, b, d, 1'b1, 1'b0);
    check({tag, "_def"}, leds_def, e_def);
    check({tag, "_dec"}, leds_dec, e_dec);
    check({tag, "_pos"}, leds_pos, e_pos);
    prev_def  = e_def;
    prev_dec  = e_dec;
    prev_pos  = e_pos;
    have_prev = 1'b1;
  endtask

  initial begin
    lit_low = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
    reset = 1'b1;
    blank = 1'b0;
    bcd   = 4'd5;
    @(posedge clk);
    #1;

    step(1'b1, 1'b0, 5, "reset");
    check("reset_lit_def", leds_def, 7'b1111111);
    check("reset_lit_pos", leds_pos, 7'b0000000);
    step(1'b0, 1'b0, 5, "first5");
    check("first5_lit", leds_def, 7'b0010010);

    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, i, $sformatf("sweep%0d", i));
    check("sweep9_lit", leds_def, 7'b0010000);
    step(1'b0, 1'b0, 0, "wrap0");
    check("wrap0_lit", leds_def, 7'b1000000);
    step(1'b0, 1'b0, 0, "stable0");

    for (int i = 10; i < 16; i++) step(1'b0, 1'b0, i, $sformatf("hex%0d", i));
    step(1'b0, 1'b0, 11, "hex_b");
    check("hex_b_lit", leds_def, 7'b0000011);
    check("hex_b_dec_lit", leds_dec, 7'b1111111);

    step(1'b0, 1'b1, 8, "blank8");
    check("blank8_lit", leds_def, 7'b1111111);
    step(1'b0, 1'b0, 8, "unblank8");
    check("unblank8_lit", leds_def, 7'b0000000);
    step(1'b1, 1'b0, 8, "rst_prio");
    check("rst_prio_lit", leds_def, 7'b1111111);
    step(1'b1, 1'b1, 3, "rst_blank");
    step(1'b0, 1'b0, 1, "pol1");
    check("pol1_lit", leds_pos, 7'b0000110);
    step(1'b1, 1'b0, 1, "pol_rst");
    check("pol_rst_lit", leds_pos, 7'b0000000);

    for (int n = 0; n < 300; n++) begin
      step(($urandom_range(15) == 0), ($urandom_range(7) == 0),
           int'($urandom_range(15)), $sformatf("rand%0d", n));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
